// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and default widths for the data memory arbiter
package dmem_arb_pkg;

   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CPU  = 2'd1,
      HOST = 2'd2
   } owner_t;

   typedef struct packed {
      logic                   req;
      logic                   wr;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [DMEM_DATA_W-1:0] wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arb_hold_ctr.sv
// rtl/dmem_arb_hold_ctr.sv - tenure counter for the current owner, saturating at MAX_HOLD
module dmem_arb_hold_ctr #(
   parameter int MAX_HOLD = 4,
   parameter int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic load1,
   input  logic clr,
   output logic at_max
);

   logic [CW-1:0] hold_cnt;

   assign at_max = (hold_cnt == CW'(MAX_HOLD));

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         hold_cnt <= '0;
      end else if (load1) begin
         hold_cnt <= CW'(1);
      end else if (inc && !at_max) begin
         hold_cnt <= hold_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/host arbiter for the single-port data memory, CPU wins ties
// Optional stall counter enabled by defining DMEM_ARB_STALL_CNT_EN.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MAX_HOLD = 4,
   parameter int STALL_W  = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cpu_req,
   input  logic               cpu_wr,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [DATA_W-1:0]  cpu_wdata,
   output logic               cpu_gnt,
   output logic               cpu_rvalid,
   input  logic               host_req,
   input  logic               host_wr,
   input  logic [ADDR_W-1:0]  host_addr,
   input  logic [DATA_W-1:0]  host_wdata,
   output logic               host_gnt,
   output logic               host_rvalid,
   output logic [DATA_W-1:0]  rdata,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_wr,
   output logic [DATA_W-1:0]  mem_wdata,
   input  logic [DATA_W-1:0]  mem_rdata,
   output logic [1:0]         owner,
   output logic [STALL_W-1:0] stall_cnt
);

   owner_t owner_q, owner_nxt;
   logic   cpu_g, host_g;
   logic   hold_inc, hold_load1, hold_clr, at_max;

   dmem_arb_hold_ctr #(.MAX_HOLD(MAX_HOLD)) u_hold (
      .clk    (clk),
      .reset  (reset),
      .inc    (hold_inc),
      .load1  (hold_load1),
      .clr    (hold_clr),
      .at_max (at_max)
   );

   // The owner keeps the port until its tenure is used up while the other side waits.
   always_comb begin
      cpu_g  = 1'b0;
      host_g = 1'b0;
      if (!reset) begin
         unique case (owner_q)
            CPU: begin
               if (cpu_req && !(host_req && at_max)) cpu_g = 1'b1;
               else if (host_req)                    host_g = 1'b1;
            end
            HOST: begin
               if (host_req && !(cpu_req && at_max)) host_g = 1'b1;
               else if (cpu_req)                     cpu_g = 1'b1;
            end
            default: begin
               if (cpu_req)       cpu_g = 1'b1;
               else if (host_req) host_g = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      owner_nxt  = IDLE;
      hold_inc   = 1'b0;
      hold_load1 = 1'b0;
      hold_clr   = 1'b0;
      if (cpu_g) begin
         owner_nxt  = CPU;
         hold_inc   = (owner_q == CPU);
         hold_load1 = (owner_q != CPU);
      end else if (host_g) begin
         owner_nxt  = HOST;
         hold_inc   = (owner_q == HOST);
         hold_load1 = (owner_q != HOST);
      end else begin
         hold_clr   = 1'b1;
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wr    = 1'b0;
      if (cpu_g) begin
         mem_addr  = cpu_addr;
         mem_wdata = cpu_wdata;
         mem_wr    = cpu_wr;
      end else if (host_g) begin
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
         mem_wr    = host_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner_q     <= IDLE;
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
      end else begin
         owner_q     <= owner_nxt;
         cpu_rvalid  <= cpu_g && !cpu_wr;
         host_rvalid <= host_g && !host_wr;
      end
   end

   assign cpu_gnt  = cpu_g;
   assign host_gnt = host_g;
   assign rdata    = mem_rdata;
   assign owner    = owner_q;

`ifdef DMEM_ARB_STALL_CNT_EN
   logic [STALL_W-1:0] stall_q;

   // Only one side can be stalled in a cycle, so a single +1 covers both ports.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
      end else if (((cpu_req && !cpu_g) || (host_req && !host_g)) && (stall_q != '1)) begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

`ifdef DMEM_ARB_STALL_CNT_EN
   localparam int STALL_ON = 1;
`else
   localparam int STALL_ON = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   dmem_req_t   cpu_r, host_r;
   logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid, mem_wr;
   logic [15:0] rdata, mem_wdata, mem_rdata;
   logic [7:0]  mem_addr;
   logic [1:0]  owner;
   logic [15:0] stall_cnt;
   logic [15:0] mem [256];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .cpu_req     (cpu_r.req),
      .cpu_wr      (cpu_r.wr),
      .cpu_addr    (cpu_r.addr),
      .cpu_wdata   (cpu_r.wdata),
      .cpu_gnt     (cpu_gnt),
      .cpu_rvalid  (cpu_rvalid),
      .host_req    (host_r.req),
      .host_wr     (host_r.wr),
      .host_addr   (host_r.addr),
      .host_wdata  (host_r.wdata),
      .host_gnt    (host_gnt),
      .host_rvalid (host_rvalid),
      .rdata       (rdata),
      .mem_addr    (mem_addr),
      .mem_wr      (mem_wr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .owner       (owner),
      .stall_cnt   (stall_cnt)
   );

   // Registered-read memory model, preloaded while reset is held.
   always @(posedge clk) begin
      if (reset) mem[8'h0A] <= 16'h1234;
      else if (mem_wr) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   logic exp_cpu [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

   initial begin
      reset  = 1'b1;
      cpu_r  = '{req: 1'b1, wr: 1'b0, addr: 8'h00, wdata: 16'h0000};
      host_r = '{req: 1'b1, wr: 1'b1, addr: 8'hFF, wdata: 16'hDEAD};
      repeat (2) cyc();
      @(negedge clk);
      check("rst_cpu_gnt", 32'(cpu_gnt), 0);
      check("rst_host_gnt", 32'(host_gnt), 0);
      check("rst_mem_wr", 32'(mem_wr), 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_owner", 32'(owner), 0);
      check("rst_stall", 32'(stall_cnt), 0);
      check("rst_rvalid", 32'({cpu_rvalid, host_rvalid}), 0);

      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("rel_cpu_gnt", 32'(cpu_gnt), 1);
      check("rel_host_gnt", 32'(host_gnt), 0);
      check("rel_mem_wr", 32'(mem_wr), 0);
      cyc();
      cpu_r.req  = 1'b0;
      host_r.req = 1'b0;
      @(negedge clk);
      check("rel_owner", 32'(owner), 1);
      check("rel_hold", 32'(dut.u_hold.hold_cnt), 1);
      check("rel_cpu_rvalid", 32'(cpu_rvalid), 1);

      // single CPU read of 0x0A
      cyc();
      cpu_r = '{req: 1'b1, wr: 1'b0, addr: 8'h0A, wdata: 16'h0000};
      @(negedge clk);
      check("rd_cpu_gnt", 32'(cpu_gnt), 1);
      check("rd_mem_addr", 32'(mem_addr), 32'h0A);
      check("rd_mem_wr", 32'(mem_wr), 0);
      cyc();
      cpu_r.req = 1'b0;
      @(negedge clk);
      check("rd_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("rd_rdata", 32'(rdata), 32'h1234);
      check("rd_host_rvalid", 32'(host_rvalid), 0);

      // both request continuously: four CPU, four HOST, then CPU
      cyc();
      cpu_r  = '{req: 1'b1, wr: 1'b0, addr: 8'h10, wdata: 16'h0000};
      host_r = '{req: 1'b1, wr: 1'b0, addr: 8'h20, wdata: 16'h0000};
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         check($sformatf("tie_cpu_gnt%0d", i), 32'(cpu_gnt), 32'(exp_cpu[i]));
         check($sformatf("tie_host_gnt%0d", i), 32'(host_gnt), 32'(!exp_cpu[i]));
         if (i == 4) begin
            check("tie_cpu_rvalid4", 32'(cpu_rvalid), 1);
            check("tie_stall4", 32'(stall_cnt), 32'(STALL_ON * 5));
         end
         if (i == 5) check("tie_host_rvalid5", 32'(host_rvalid), 1);
         if (i == 8) check("tie_stall8", 32'(stall_cnt), 32'(STALL_ON * 9));
         cyc();
      end

      // host write then CPU read of the same word
      cpu_r.req = 1'b0;
      host_r    = '{req: 1'b1, wr: 1'b1, addr: 8'h29, wdata: 16'hBEEF};
      @(negedge clk);
      check("wr_host_gnt", 32'(host_gnt), 1);
      check("wr_mem_wr", 32'(mem_wr), 1);
      check("wr_mem_addr", 32'(mem_addr), 32'h29);
      check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
      cyc();
      host_r.req = 1'b0;
      cpu_r      = '{req: 1'b1, wr: 1'b0, addr: 8'h29, wdata: 16'h0000};
      @(negedge clk);
      check("fw_cpu_gnt", 32'(cpu_gnt), 1);
      check("fw_mem_wr", 32'(mem_wr), 0);
      check("fw_host_rvalid", 32'(host_rvalid), 0);
      cyc();
      cpu_r.req = 1'b0;
      @(negedge clk);
      check("fw_cpu_rvalid", 32'(cpu_rvalid), 1);
      check("fw_rdata", 32'(rdata), 32'hBEEF);

      // host owns with hold 2, then drops while CPU requests
      cyc();
      host_r = '{req: 1'b1, wr: 1'b0, addr: 8'h0A, wdata: 16'h0000};
      @(negedge clk);
      check("drop_host_gnt0", 32'(host_gnt), 1);
      cyc();
      cyc();
      host_r.req = 1'b0;
      cpu_r.req  = 1'b1;
      @(negedge clk);
      check("drop_pre_owner", 32'(owner), 2);
      check("drop_pre_hold", 32'(dut.u_hold.hold_cnt), 2);
      check("drop_cpu_gnt", 32'(cpu_gnt), 1);
      check("drop_host_gnt", 32'(host_gnt), 0);
      check("drop_host_rvalid", 32'(host_rvalid), 1);
      cyc();
      @(negedge clk);
      check("drop_owner", 32'(owner), 1);
      check("drop_hold", 32'(dut.u_hold.hold_cnt), 1);

      // reset in the cycle after a granted host read
      cpu_r.req = 1'b0;
      host_r    = '{req: 1'b1, wr: 1'b0, addr: 8'h29, wdata: 16'h0000};
      cyc();
      @(negedge clk);
      check("mid_host_gnt", 32'(host_gnt), 1);
      cyc();
      reset = 1'b1;
      @(negedge clk);
      check("mid_rvalid_pend", 32'(host_rvalid), 1);
      check("mid_rst_gnt", 32'(host_gnt), 0);
      check("mid_rst_addr", 32'(mem_addr), 0);
      cyc();
      @(negedge clk);
      check("mid_host_rvalid", 32'(host_rvalid), 0);
      check("mid_owner", 32'(owner), 0);
      check("mid_stall", 32'(stall_cnt), 0);
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
